hack_alu_pipe: RTL and testbench
================================

Name: hack_alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational Hack ALU. It uses the same six control bits (zx, nx, zy, ny, f, no) and the same zr/ng flags.
- Generalised to WIDTH bits and split into two register stages.
- Adds a valid/ready handshake with full backpressure, plus carry and signed-overflow flags from the adder.
- Sits between the CPU decode stage and the writeback path.

Parameters:
- WIDTH, 16, operand and result width in bits; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand and control bundle is valid this cycle.
- in_ready  output  1  stage 1 can accept a bundle this cycle.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- zx, nx, zy, ny, f, no  input  1 each  Hack control bits, sampled with x and y.
- out_valid  output  1  result bundle is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- o  output  WIDTH  result.
- zr  output  1  o == 0.
- ng  output  1  o[WIDTH-1].
- cy  output  1  carry out of the add; 0 when f=0.
- ov  output  1  signed overflow of the add; 0 when f=0.

Behaviour:
- Reset: asynchronous, active-high. While reset is high:
  - both stage valid bits clear;
  - out_valid=0; o, zr, ng, cy and ov are all 0;
  - in_ready=1.
- Stage 1 (registered on accept): stores
  - xs = nx ? ~(zx ? 0 : x) : (zx ? 0 : x);
  - ys, computed the same way from zy, ny and y;
  - f and no.
- Stage 2 (registered on advance):
  - r = f ? xs + ys (WIDTH-bit sum) : xs & ys;
  - o = no ? ~r : r;
  - cy = f & carry-out of bit WIDTH-1;
  - ov = f & (xs[MSB] == ys[MSB]) & (sum[MSB] != xs[MSB]);
  - zr and ng are computed from the final o, after no is applied.
  - cy and ov describe the pre-negation add and are not modified by no.
- Stage 2 outputs are registered and drive the output ports directly.
- Handshake:
  - adv2 = s1_valid & (~s2_valid | out_ready);
  - in_ready = ~s1_valid | adv2 (combinational, no path from in_valid);
  - a transfer in occurs when in_valid & in_ready;
  - a transfer out occurs when out_valid & out_ready.
- Latency: 2 cycles from input acceptance to out_valid, with no stalls. Throughput is 1 bundle per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0:
  - o, zr, ng, cy and ov are held stable;
  - stage 1 holds its contents;
  - in_ready=0 if stage 1 is occupied.
- Simultaneous events: in the same cycle, stage 2 may emit, stage 1 may advance and a new input may be accepted. No bubble is inserted and order is strictly FIFO.
- Valid-bit updates:
  - s2_valid clears only on a transfer out with no advance into stage 2;
  - s1_valid clears only when stage 1 advances with no new accept.
- Inputs are ignored when in_valid=0. Data in stages whose valid bit is 0 is don't-care, except that outputs read 0 after reset.
- Reset mid-operation: all in-flight bundles are discarded. No partial result appears after reset deasserts.
- Width rule: all arithmetic is modulo 2^WIDTH; no sign extension.

Test Plan:
All cases use WIDTH=16 unless stated; cases 1–4 hold out_ready=1.
- Add: x=0x0005, y=0x0003, f=1, other controls 0 → 2 cycles later out_valid=1, o=0x0008, zr=0, ng=0, cy=0, ov=0.
- Signed overflow: x=0x7FFF, y=0x0001, f=1 → o=0x8000, ng=1, ov=1, cy=0, zr=0. Carry: x=0xFFFF, y=0x0001, f=1 → o=0x0000, zr=1, cy=1, ov=0.
- Hack control table sweep: x=0x000A, y=0x0003.
  - x-y (nx=1, f=1, no=1) → 0x0007, cy=0, ov=0.
  - x&y (all controls 0) → 0x0002.
  - -1 (zx=1, nx=1, zy=1, f=1) → 0xFFFF, ng=1, cy=0.
  - !x (zy=1, ny=1, no=1) → 0xFFF5, ng=1.
- Throughput: 4 back-to-back bundles giving sums 1, 2, 3, 4 → out_valid high on 4 consecutive cycles starting 2 cycles after the first accept, with o=1, 2, 3, 4 in order.
- Backpressure: out_ready=0 and bundles A, B, C presented back-to-back.
  - A and B are accepted; in_ready=0 on the next cycle; C is held and o=A is stable.
  - Raising out_ready yields A, B, C in consecutive cycles, with nothing dropped or duplicated.
- Reset mid-flight: both stages valid, assert reset asynchronously between clock edges.
  - out_valid=0 and o=0 immediately; in_ready=1.
  - After release, no output appears until a new bundle is accepted. Repeat with WIDTH=8 and x=0x7F, y=0x01, f=1 → o=0x80, ov=1, ng=1.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshake and full backpressure.
// Stage 1 captures the zx/nx/zy/ny-conditioned operands plus f/no; stage 2
// performs the add or AND, applies the output negation and derives the flags.
// Carry and signed overflow describe the raw add and are not touched by no.
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    localparam int MSB = WIDTH - 1;

    // Hack operand conditioning: optionally zero, then optionally invert.
    function automatic logic [WIDTH-1:0] prep_operand(
        input logic [WIDTH-1:0] v,
        input logic             z,
        input logic             n
    );
        logic [WIDTH-1:0] t;
        t = z ? {WIDTH{1'b0}} : v;
        return n ? ~t : t;
    endfunction

    // Stage 1 registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic             r_f;
    logic             r_no;

    // Stage 2 registers (drive the output ports directly)
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_o;
    logic             r_zr;
    logic             r_ng;
    logic             r_cy;
    logic             r_ov;

    // Handshake and datapath wires
    logic             w_adv2;
    logic             w_accept;
    logic             w_emit;
    logic [WIDTH-1:0] w_xs_in;
    logic [WIDTH-1:0] w_ys_in;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_o;
    logic             w_cy;
    logic             w_ov;

    // Stage 1 may hand over whenever stage 2 is empty or is emitting now;
    // in_ready never depends on in_valid.
    assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_adv2;
    assign w_accept = in_valid & in_ready;
    assign w_emit   = r_s2_valid & out_ready;

    assign w_xs_in = prep_operand(x, zx, nx);
    assign w_ys_in = prep_operand(y, zy, ny);

    // Stage 2 combinational compute: add or AND, negate, carry and overflow.
    always_comb begin
        w_sum = {1'b0, r_xs} + {1'b0, r_ys};
        w_r   = r_xs & r_ys;
        w_o   = w_r;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        if (r_f) begin
            w_r  = w_sum[MSB:0];
            w_cy = w_sum[WIDTH];
            w_ov = (r_xs[MSB] == r_ys[MSB]) & (w_sum[MSB] != r_xs[MSB]);
        end else begin
            w_r  = r_xs & r_ys;
            w_cy = 1'b0;
            w_ov = 1'b0;
        end
        if (r_no) begin
            w_o = ~w_r;
        end else begin
            w_o = w_r;
        end
    end

    // Stage 1 register: capture conditioned operands on accept, drain on advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_xs       <= {WIDTH{1'b0}};
            r_ys       <= {WIDTH{1'b0}};
            r_f        <= 1'b0;
            r_no       <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_xs       <= w_xs_in;
            r_ys       <= w_ys_in;
            r_f        <= f;
            r_no       <= no;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: load result on advance, hold under stall, clear valid on emit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_o        <= {WIDTH{1'b0}};
            r_zr       <= 1'b0;
            r_ng       <= 1'b0;
            r_cy       <= 1'b0;
            r_ov       <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= 1'b1;
            r_o        <= w_o;
            r_zr       <= (w_o == {WIDTH{1'b0}});
            r_ng       <= w_o[MSB];
            r_cy       <= w_cy;
            r_ov       <= w_ov;
        end else if (w_emit) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign o         = r_o;
    assign zr        = r_zr;
    assign ng        = r_ng;
    assign cy        = r_cy;
    assign ov        = r_ov;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Bench for hack_alu_pipe: queue-based behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_hack_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x, y, o;
    logic        zx, nx, zy, ny, f, no;
    logic        zr, ng, cy, ov;

    // second instance at WIDTH=8
    logic        iv8, ir8, vld8, or8;
    logic [7:0]  x8, y8, o8;
    logic [5:0]  c8;
    logic        zr8, ng8, cy8, ov8;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [15:0] o;
        logic        zr, ng, cy, ov;
        int          age;
    } item_t;

    typedef struct {
        logic [15:0] o;
        logic        zr, ng, cy, ov;
        int          cyc;
    } obs_t;

    item_t q[$];
    obs_t  obs[$];

    hack_alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
    );

    hack_alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .x(x8), .y(y8), .zx(c8[5]), .nx(c8[4]), .zy(c8[3]), .ny(c8[2]),
        .f(c8[1]), .no(c8[0]),
        .out_valid(vld8), .out_ready(or8),
        .o(o8), .zr(zr8), .ng(ng8), .cy(cy8), .ov(ov8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ideal Hack ALU from integer arithmetic; ctl = {zx,nx,zy,ny,f,no}
    function automatic item_t calc(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        item_t it;
        int xa, yb, s, r, sa, sb;
        xa = c[5] ? 0 : int'(a);
        if (c[4]) xa = 65535 - xa;
        yb = c[3] ? 0 : int'(b);
        if (c[2]) yb = 65535 - yb;
        if (c[1]) begin
            s  = xa + yb;
            r  = s % 65536;
            it.cy = (s >= 65536);
            sa = (xa >= 32768) ? xa - 65536 : xa;
            sb = (yb >= 32768) ? yb - 65536 : yb;
            it.ov = ((sa + sb) > 32767) || ((sa + sb) < -32768);
        end else begin
            r  = xa & yb;
            it.cy = 1'b0;
            it.ov = 1'b0;
        end
        if (c[0]) r = 65535 - r;
        it.o   = r[15:0];
        it.zr  = (r == 0);
        it.ng  = (r >= 32768);
        it.age = 0;
        return it;
    endfunction

    always @(posedge clk) cyc++;

    // Transaction-level model: FIFO of at most two in-flight bundles; the
    // oldest becomes visible one edge after its acceptance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            automatic bit acc  = in_valid && ((q.size() < 2) || out_ready);
            automatic bit emit = (q.size() > 0) && (q[0].age >= 1) && out_ready;
            if (emit) void'(q.pop_front());
            foreach (q[i]) if (q[i].age < 4) q[i].age++;
            if (acc) q.push_back(calc(x, y, {zx, nx, zy, ny, f, no}));
        end
    end

    // Per-cycle comparison against the model, and log of emitted results.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_o", {16'd0, o}, 32'd0);
            chk("rst_flags", {28'd0, zr, ng, cy, ov}, 32'd0);
        end else begin
            automatic bit exp_v = (q.size() > 0) && (q[0].age >= 1);
            chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                chk("o", {16'd0, o}, {16'd0, q[0].o});
                chk("flags", {28'd0, zr, ng, cy, ov},
                    {28'd0, q[0].zr, q[0].ng, q[0].cy, q[0].ov});
            end
            if (out_valid && out_ready) begin
                obs_t e;
                e.o = o; e.zr = zr; e.ng = ng; e.cy = cy; e.ov = ov; e.cyc = cyc;
                obs.push_back(e);
            end
        end
    end

    // Present one bundle and hold it until accepted (bounded wait).
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        int n;
        x = a; y = b; {zx, nx, zy, ny, f, no} = c; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single bundle with out_ready=1 and literal expectations incl. 2-cycle latency.
    task automatic single(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [5:0] c, input logic [15:0] eo, input logic [3:0] efl);
        int c0;
        obs.delete();
        c0 = cyc;
        send(a, b, c);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_count"}, obs.size(), 32'd1);
        if (obs.size() >= 1) begin
            chk({nm, "_o"}, {16'd0, obs[0].o}, {16'd0, eo});
            chk({nm, "_zr_ng_cy_ov"}, {28'd0, obs[0].zr, obs[0].ng, obs[0].cy, obs[0].ov},
                {28'd0, efl});
            chk({nm, "_latency"}, obs[0].cyc, c0 + 2);
        end
    endtask

    initial begin
        item_t m;
        int c0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = 16'h0; y = 16'h0; {zx, nx, zy, ny, f, no} = 6'b0;
        iv8 = 1'b0; or8 = 1'b1; x8 = 8'h0; y8 = 8'h0; c8 = 6'b0;

        // pin the model with hand-computed values
        m = calc(16'h000A, 16'h0003, 6'b010011);
        chk("model_x_minus_y", {16'd0, m.o}, 32'h0007);
        m = calc(16'h7FFF, 16'h0001, 6'b000010);
        chk("model_ovf", {28'd0, m.zr, m.ng, m.cy, m.ov}, 32'b0101);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // flags field order: {zr, ng, cy, ov}
        single("add",      16'h0005, 16'h0003, 6'b000010, 16'h0008, 4'b0000);
        single("ovf",      16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 4'b0101);
        single("carry",    16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 4'b1010);
        single("x_sub_y",  16'h000A, 16'h0003, 6'b010011, 16'h0007, 4'b0000);
        single("x_and_y",  16'h000A, 16'h0003, 6'b000000, 16'h0002, 4'b0000);
        single("minus1",   16'h000A, 16'h0003, 6'b111010, 16'hFFFF, 4'b0100);
        single("not_x",    16'h000A, 16'h0003, 6'b001101, 16'hFFF5, 4'b0100);

        // throughput: four back-to-back sums 1..4
        obs.delete();
        c0 = cyc;
        for (int i = 1; i <= 4; i++) send(16'(i), 16'h0000, 6'b000010);
        repeat (3) @(posedge clk);
        #1;
        chk("tput_count", obs.size(), 32'd4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("tput_o", {16'd0, obs[i].o}, 32'(i + 1));
                chk("tput_cycle", obs[i].cyc, c0 + 2 + i);
            end
        end

        // backpressure: A and B fill the pipe, C waits
        obs.delete();
        out_ready = 1'b0;
        send(16'h1111, 16'h0000, 6'b000010);
        send(16'h2222, 16'h0000, 6'b000010);
        fork
            send(16'h3333, 16'h0000, 6'b000010);
            begin
                @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_o_A", {16'd0, o}, 32'h1111);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_hold_o", {16'd0, o}, 32'h1111);
                    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("bp_first", {16'd0, obs[0].o}, 32'h1111);
            chk("bp_second", {16'd0, obs[1].o}, 32'h2222);
            chk("bp_third", {16'd0, obs[2].o}, 32'h3333);
            chk("bp_consec1", obs[1].cyc, obs[0].cyc + 1);
            chk("bp_consec2", obs[2].cyc, obs[0].cyc + 2);
        end

        // reset mid-flight: both stages full in both instances
        out_ready = 1'b0;
        or8 = 1'b0;
        x8 = 8'h11; y8 = 8'h00; c8 = 6'b000010; iv8 = 1'b1;
        send(16'h4444, 16'h0000, 6'b000010);
        send(16'h5555, 16'h0000, 6'b000010);
        iv8 = 1'b0;
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, 32'b10);
        chk("pre_rst_full8", {30'd0, vld8, ir8}, 32'b10);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_o", {16'd0, o}, 32'd0);
        chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_flags", {28'd0, zr, ng, cy, ov}, 32'd0);
        chk("async_rst8_valid_o", {23'd0, vld8, o8}, 32'd0);
        chk("async_rst8_ready", {31'd0, ir8}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        or8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
            chk("post_rst_idle8", {31'd0, vld8}, 32'd0);
        end
        @(posedge clk); #1;

        // WIDTH=8 overflow case
        x8 = 8'h7F; y8 = 8'h01; c8 = 6'b000010; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("w8_valid", {31'd0, vld8}, 32'd1);
        chk("w8_o", {24'd0, o8}, 32'h80);
        chk("w8_flags", {28'd0, zr8, ng8, cy8, ov8}, 32'b0101);
        @(posedge clk); #1;

        // fresh bundle after reset flows normally
        single("post_rst", 16'h0002, 16'h0003, 6'b000010, 16'h0005, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
